// File: rtl/hazard_sched_unit.sv
// Pipeline hazard/stall/flush sequencer with E-stage forwarding and a data-memory wait FSM.
// Optional performance counters are built when PERF_CNT_EN is defined.
module hazard_sched_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             mem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
  localparam logic [WCNT_W-1:0] TO_VAL   = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t            state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              mem_err_q;

  logic mwait;
  logic lw_stall;
  logic frozen;

  // M-stage result beats W-stage result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       rw_m,
                                         input logic [4:0] rd_m,
                                         input logic       rw_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0) begin
      if (rw_m && (rd_m == rs))      sel = 2'b10;
      else if (rw_w && (rd_w == rs)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign mwait    = MemAccessM & ~mem_ready;
  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));
  assign frozen   = (state_q == S_ERROR) | mwait;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      // A frozen pipe holds E, so branch and load-use are re-evaluated on release.
      if (frozen) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end
    end
  end

  assign mem_err = mem_err_q & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mwait) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= WCNT_W'(1);
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
          end else begin
            if (wait_cnt_q != WCNT_MAX) wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
            if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TO_VAL)) begin
              state_q   <= S_ERROR;
              mem_err_q <= 1'b1;
            end
          end
        end
        S_ERROR: mem_err_q <= 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = stall_cnt_q + CNT_W'(StallF);
  assign flush_cnt_d = flush_cnt_q + CNT_W'(FlushE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Bench for hazard_sched_unit: vector table, hand sequences for the memory-wait
// corners, and a randomized run against a rule-level reference model.
module tb_hazard_sched_unit;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned m_stall_cnt, m_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference-model state: sticky error, waiting flag, cycles spent waiting.
  bit m_err;
  bit m_waiting;
  int m_cnt;

  always #5 clk = ~clk;

  hazard_sched_unit #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .mem_ready(mem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Output word: {FA[1:0],FB[1:0],SF,SD,SE,SM,FD,FE,FW,merr}
  function automatic logic [11:0] outs();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
            FlushD, FlushE, FlushW, mem_err};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] model_exp();
    bit lw, frz;
    logic [11:0] e;
    if (reset) return 12'h000;
    lw  = (ResultSrcE == 2'b01) && (RdE != 0) && (Rs1D == RdE || Rs2D == RdE);
    frz = m_err || (MemAccessM && !mem_ready);
    e   = {m_fwd(Rs1E), m_fwd(Rs2E), 8'h00};
    if (frz) e[7:1] = 7'b1111001;
    else     e[7:1] = {lw, lw, 1'b0, 1'b0, PCSrcE, lw | PCSrcE, 1'b0};
    e[0] = m_err;
    return e;
  endfunction

  task automatic model_advance();
    if (reset) begin
      m_err = 0; m_waiting = 0; m_cnt = 0;
    end else if (m_err) begin
      m_err = 1;
    end else if (!m_waiting) begin
      if (MemAccessM && !mem_ready) begin m_waiting = 1; m_cnt = 1; end
    end else if (mem_ready) begin
      m_waiting = 0; m_cnt = 0;
    end else if (m_cnt >= TO) begin
      m_err = 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemAccessM = 0; mem_ready = 1;
  endtask

  // Check outputs mid-cycle against exp, then advance model and clock.
  task automatic step(input string name, input logic [11:0] exp);
    @(negedge clk);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", name, outs(), exp);
    end
`ifdef PERF_CNT_EN
    checks++;
    if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
      errors++;
      $display("FAIL %s_perf: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               name, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
    end
    if (reset) begin m_stall_cnt = 0; m_flush_cnt = 0; end
    else begin m_stall_cnt += exp[7]; m_flush_cnt += exp[2]; end
`endif
    model_advance();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsrc;
    logic       rwm, rww, pcsrc, macc, mrdy;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"fwd_m_beats_w", 0,0,5,0,0,5,5, 2'b00, 1,1,0,0,1, 12'b10_00_0000_000_0};
    vecs[1] = '{"fwd_x0",        0,0,0,0,0,5,5, 2'b00, 1,1,0,0,1, 12'b00_00_0000_000_0};
    vecs[2] = '{"fwd_w_both",    0,0,3,3,0,1,3, 2'b00, 1,1,0,0,1, 12'b01_01_0000_000_0};
    vecs[3] = '{"fwd_m_nowrite", 0,0,4,4,0,4,4, 2'b00, 0,1,0,0,1, 12'b01_01_0000_000_0};
    vecs[4] = '{"load_use_rs2",  0,7,0,0,7,0,0, 2'b01, 0,0,0,0,1, 12'b00_00_1100_010_0};
    vecs[5] = '{"load_rd_x0",    0,0,0,0,0,0,0, 2'b01, 0,0,0,0,1, 12'b00_00_0000_000_0};
    vecs[6] = '{"not_a_load",    7,0,0,0,7,0,0, 2'b10, 0,0,0,0,1, 12'b00_00_0000_000_0};
    vecs[7] = '{"branch",        0,0,0,0,0,0,0, 2'b00, 0,0,1,0,1, 12'b00_00_0000_110_0};
    vecs[8] = '{"branch_lu",     7,0,0,0,7,0,0, 2'b01, 0,0,1,0,1, 12'b00_00_1100_110_0};
    vecs[9] = '{"single_ack",    0,0,0,0,0,0,0, 2'b00, 0,0,0,1,1, 12'b00_00_0000_000_0};

`ifdef PERF_CNT_EN
    m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    m_err = 0; m_waiting = 0; m_cnt = 0;
    clear_inputs();
    reset = 1'b1;
    RdM = 5; RegWriteM = 1; Rs1E = 5; PCSrcE = 1;
    step("reset_outputs", 12'h000);
    clear_inputs();
    reset = 1'b0;
    step("after_reset", 12'h000);

    foreach (vecs[i]) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
      Rs2E = vecs[i].rs2e; RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      ResultSrcE = vecs[i].rsrc; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      PCSrcE = vecs[i].pcsrc; MemAccessM = vecs[i].macc; mem_ready = vecs[i].mrdy;
      step(vecs[i].name, vecs[i].exp);
    end
    clear_inputs();
    step("idle_after_table", 12'h000);

    // Three-cycle memory wait with a branch pending: freeze wins, no FlushD.
    MemAccessM = 1; mem_ready = 0; PCSrcE = 1;
    for (int c = 0; c < 3; c++) step("mwait_freeze", 12'b00_00_1111_001_0);
    mem_ready = 1; PCSrcE = 0;
    step("mwait_release", 12'h000);
    clear_inputs();
    step("mwait_idle", 12'h000);

    // Stuck memory: IDLE cycle + 4 WAIT cycles, then sticky error.
    MemAccessM = 1; mem_ready = 0;
    for (int c = 0; c < 5; c++) step("timeout_wait", 12'b00_00_1111_001_0);
    for (int c = 0; c < 3; c++) step("timeout_err", 12'b00_00_1111_001_1);
    clear_inputs();
    PCSrcE = 1;
    step("err_sticky", 12'b00_00_1111_001_1);
    reset = 1'b1;
    RdW = 9; RegWriteW = 1; Rs2E = 9;
    #1;
    checks++;
    if (outs() !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got %03h expected 000", outs());
    end
    step("err_reset", 12'h000);
    reset = 1'b0;
    clear_inputs();
    step("err_cleared", 12'h000);

    // Randomized run with occasional resets (including mid-wait/error).
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 39) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemAccessM = 1'($urandom_range(0, 1));
      mem_ready  = ($urandom_range(0, 2) != 0);
      step("random", model_exp());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
